// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Instructions are fixed three-byte records: opcode, operand1, operand2.
package fetch_pkg;

    localparam int          INSTR_BYTES = 3;
    localparam logic [7:0]  HALT_OPCODE = 8'hFF;
    localparam logic [15:0] RESET_PC    = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_HOLD   = 3'd4,
        ST_HALT   = 3'd5,
        ST_CLEAR  = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Control, program-RAM and decode-side signals of the fetch sequencer.
// master = the sequencer itself, slave = RAM/decode/control environment.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic              clear_req;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_clear;
    logic [DATA_W-1:0] mem_datain;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_opcode;
    logic [DATA_W-1:0] instr_op1;
    logic [DATA_W-1:0] instr_op2;
    logic [ADDR_W-1:0] instr_pc;

    logic              halted;
    logic              busy;

    modport master (
        input  start, clear_req, jump_valid, jump_addr,
        input  mem_datain, instr_ready,
        output mem_address, mem_clear,
        output instr_valid, instr_opcode, instr_op1, instr_op2, instr_pc,
        output halted, busy
    );

    modport slave (
        output start, clear_req, jump_valid, jump_addr,
        output mem_datain, instr_ready,
        input  mem_address, mem_clear,
        input  instr_valid, instr_opcode, instr_op1, instr_op2, instr_pc,
        input  halted, busy
    );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetches 3-byte instructions from a combinational-read RAM, one byte per cycle.
// Latency: start edge + 3 cycles to instr_valid; holds payload until instr_ready.
module instr_fetch_ctrl #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = fetch_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_ctrl_if.master bus
);
    import fetch_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;

    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              valid_q;
    logic              halted_q;

    logic              handshake;
    logic              is_halt;
    logic              in_fetch;
    logic              fetch_keep;
    logic [ADDR_W-1:0] pc_step;

    assign handshake  = valid_q & bus.instr_ready;
    assign is_halt    = (bus.mem_datain == HALT_OPCODE);
    assign in_fetch   = (state == ST_FETCH0) || (state == ST_FETCH1) ||
                        (state == ST_FETCH2);
    // A jump during any fetch byte discards the partial instruction.
    assign fetch_keep = in_fetch && !bus.jump_valid;
    assign pc_step    = pc + ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE: begin
                if (bus.jump_valid) begin
                    pc_nxt = bus.jump_addr;
                end
                if (bus.clear_req) begin
                    state_nxt = ST_CLEAR;
                end else if (bus.start) begin
                    state_nxt = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                if (bus.jump_valid) begin
                    pc_nxt    = bus.jump_addr;
                    state_nxt = ST_FETCH0;
                end else if (is_halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                if (bus.jump_valid) begin
                    pc_nxt    = bus.jump_addr;
                    state_nxt = ST_FETCH0;
                end else begin
                    state_nxt = ST_FETCH2;
                end
            end
            ST_FETCH2: begin
                if (bus.jump_valid) begin
                    pc_nxt    = bus.jump_addr;
                    state_nxt = ST_FETCH0;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Jump requests only count when they coincide with acceptance.
                if (handshake) begin
                    pc_nxt    = bus.jump_valid ? bus.jump_addr : pc_step;
                    state_nxt = ST_FETCH0;
                end
            end
            ST_HALT: begin
                if (bus.clear_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pc_nxt    = RESET_PC;
                state_nxt = ST_IDLE;
            end
            default: begin
                pc_nxt    = RESET_PC;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            instr_pc_q <= '0;
        end else if (fetch_keep) begin
            case (state)
                ST_FETCH0: begin
                    opcode_q   <= bus.mem_datain;
                    instr_pc_q <= pc;
                end
                ST_FETCH1: op1_q <= bus.mem_datain;
                ST_FETCH2: op2_q <= bus.mem_datain;
                default:   opcode_q <= opcode_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (fetch_keep && (state == ST_FETCH2)) begin
            valid_q <= 1'b1;
        end else if (handshake) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (fetch_keep && (state == ST_FETCH0) && is_halt) begin
            halted_q <= 1'b1;
        end else if (state == ST_CLEAR) begin
            halted_q <= 1'b0;
        end
    end

    always_comb begin
        bus.mem_address = pc;
        case (state)
            ST_FETCH1: bus.mem_address = pc + ADDR_W'(1);
            ST_FETCH2: bus.mem_address = pc + ADDR_W'(2);
            default:   bus.mem_address = pc;
        endcase
    end

    assign bus.mem_clear    = (state == ST_CLEAR);
    assign bus.instr_valid  = valid_q;
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_op1    = op1_q;
    assign bus.instr_op2    = op2_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.halted       = halted_q;
    assign bus.busy         = in_fetch || (state == ST_HOLD);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: 64 KiB byte-array program RAM and a reference
// model where an instruction at p is simply bytes p, p+1, p+2 (mod 2^16).
module tb_instr_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] ram [0:65535];
    assign bus.mem_datain = ram[bus.mem_address];

    always @(posedge clk) begin
        if (bus.mem_clear) begin
            for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [39:0] model_instr(input logic [15:0] p);
        logic [15:0] p1;
        logic [15:0] p2;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        return {ram[p], ram[p1], ram[p2], p};
    endfunction

    function automatic logic [39:0] observed();
        return {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_pc};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.clear_req   = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_addr   = 16'h0000;
        bus.instr_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (bus.instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if ({bus.instr_valid, bus.halted, bus.mem_clear, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus.instr_valid, bus.halted, bus.mem_clear, bus.busy});
        end
        n_cmp++;
        if (bus.mem_address !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_addr got=%h exp=0000", bus.mem_address);
        end
        n_cmp++;
        if (observed() !== 40'h0) begin
            n_err++;
            $display("FAIL reset_payload got=%h exp=0", observed());
        end
        reset = 1'b0;
    endtask

    task automatic test_program();
        logic [15:0] exp_pc;
        int  c;
        bit  ok;
        bit  first;
        bit  saw_valid;
        int  n_halt;
        ram[0] = 8'h00; ram[1] = 8'h01; ram[2] = 8'h82;
        ram[3] = 8'h44; ram[4] = 8'h02; ram[5] = 8'h02; ram[6] = 8'hFF;
        exp_pc = 16'h0000;
        first  = 1'b1;
        bus.start = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'h0000 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL prog_first_fetch addr=%h busy=%b exp=0000/1", bus.mem_address, bus.busy);
        end
        while (ram[exp_pc] != 8'hFF && exp_pc < 16'd30) begin
            wait_valid(10, c, ok);
            n_cmp++;
            if (!ok || c != (first ? 3 : 4)) begin
                n_err++;
                $display("FAIL prog_latency got=%0d ok=%0d exp=%0d", c, ok, first ? 3 : 4);
            end
            n_cmp++;
            if (observed() !== model_instr(exp_pc)) begin
                n_err++;
                $display("FAIL prog_payload got=%h exp=%h", observed(), model_instr(exp_pc));
            end
            exp_pc = exp_pc + 16'd3;
            first  = 1'b0;
        end
        saw_valid = 1'b0;
        n_halt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_halt++;
            if (bus.instr_valid === 1'b1) saw_valid = 1'b1;
            if (bus.halted === 1'b1) break;
        end
        n_cmp++;
        if (bus.halted !== 1'b1 || n_halt != 2 || saw_valid) begin
            n_err++;
            $display("FAIL prog_halt halted=%b cycles=%0d saw_valid=%0d exp=1/2/0",
                     bus.halted, n_halt, saw_valid);
        end
        n_cmp++;
        if (bus.mem_address !== exp_pc || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL prog_halt_addr got=%h busy=%b exp=%h/0", bus.mem_address, bus.busy, exp_pc);
        end
        bus.start = 1'b1;
        bus.jump_valid = 1'b1;
        bus.jump_addr = 16'h1234;
        tick();
        tick();
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.mem_address !== exp_pc || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halt_ignores halted=%b addr=%h valid=%b exp=1/%h/0",
                     bus.halted, bus.mem_address, bus.instr_valid, exp_pc);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        bus.clear_req = 1'b1;
        tick();
        n_cmp++;
        if (bus.mem_clear !== 1'b1) begin
            n_err++;
            $display("FAIL clear_strobe got=%b exp=1", bus.mem_clear);
        end
        bus.clear_req = 1'b0;
        tick();
        n_cmp++;
        if ({bus.mem_clear, bus.halted, bus.busy} !== 3'b000 || bus.mem_address !== 16'h0000) begin
            n_err++;
            $display("FAIL clear_after clr/halt/busy=%b addr=%h exp=000/0000",
                     {bus.mem_clear, bus.halted, bus.busy}, bus.mem_address);
        end
        tick();
        n_cmp++;
        if (bus.mem_clear !== 1'b0) begin
            n_err++;
            $display("FAIL clear_one_cycle got=%b exp=0", bus.mem_clear);
        end
    endtask

    task automatic test_clear_ignored();
        ram[0] = 8'h05; ram[1] = 8'h06; ram[2] = 8'h07;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.mem_address !== 16'h0002) begin
            n_err++;
            $display("FAIL fetch2_addr got=%h exp=0002", bus.mem_address);
        end
        bus.clear_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.mem_clear !== 1'b0 || bus.instr_valid !== 1'b1 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL clear_ignored clr=%b valid=%b busy=%b exp=0/1/1",
                         bus.mem_clear, bus.instr_valid, bus.busy);
            end
        end
        bus.clear_req = 1'b0;
        n_cmp++;
        if (observed() !== model_instr(16'h0000)) begin
            n_err++;
            $display("FAIL clear_ign_payload got=%h exp=%h", observed(), model_instr(16'h0000));
        end
    endtask

    logic [15:0] jump_tgt;

    task automatic test_jump();
        int c;
        bit ok;
        ram[16'h000A] = 8'h00; ram[16'h000B] = 8'h02; ram[16'h000C] = 8'h80;
        bus.instr_ready = 1'b1;
        bus.jump_valid = 1'b1;
        bus.jump_addr = 16'h000A;
        tick();
        bus.instr_ready = 1'b0;
        bus.jump_valid = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'h000A) begin
            n_err++;
            $display("FAIL jump_hs_addr got=%h exp=000A", bus.mem_address);
        end
        wait_valid(10, c, ok);
        n_cmp++;
        if (!ok || c != 3 || observed() !== model_instr(16'h000A)) begin
            n_err++;
            $display("FAIL jump_hs_instr got=%h cyc=%0d exp=%h/3", observed(), c, model_instr(16'h000A));
        end
        jump_tgt = 16'($urandom_range(16'h0100, 16'hF000));
        ram[jump_tgt] = 8'($urandom_range(0, 254));
        ram[jump_tgt + 16'd1] = 8'($urandom);
        ram[jump_tgt + 16'd2] = 8'($urandom);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'h000D) begin
            n_err++;
            $display("FAIL jump_next_pc got=%h exp=000D", bus.mem_address);
        end
        tick();
        n_cmp++;
        if (bus.mem_address !== 16'h000E) begin
            n_err++;
            $display("FAIL jump_fetch1_addr got=%h exp=000E", bus.mem_address);
        end
        bus.jump_valid = 1'b1;
        bus.jump_addr = jump_tgt;
        tick();
        bus.jump_valid = 1'b0;
        n_cmp++;
        if (bus.mem_address !== jump_tgt || bus.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_abort addr=%h valid=%b exp=%h/0", bus.mem_address, bus.instr_valid, jump_tgt);
        end
        wait_valid(10, c, ok);
        n_cmp++;
        if (!ok || c != 3 || observed() !== model_instr(jump_tgt)) begin
            n_err++;
            $display("FAIL jump_abort_instr got=%h cyc=%0d exp=%h/3", observed(), c, model_instr(jump_tgt));
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] exp_p;
        exp_p = model_instr(jump_tgt);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || observed() !== exp_p || bus.mem_address !== jump_tgt) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d valid=%b got=%h addr=%h exp=1/%h/%h",
                         i, bus.instr_valid, observed(), bus.mem_address, exp_p, jump_tgt);
            end
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.mem_address !== jump_tgt + 16'd3) begin
            n_err++;
            $display("FAIL bp_accept valid=%b addr=%h exp=0/%h", bus.instr_valid, bus.mem_address, jump_tgt + 16'd3);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33;
        bus.jump_valid = 1'b1;
        bus.jump_addr = 16'hFFFE;
        tick();
        bus.jump_valid = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'hFFFE || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_idle_jump addr=%h busy=%b exp=FFFE/0", bus.mem_address, bus.busy);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.mem_address !== 16'hFFFE + 16'(i)) begin
                n_err++;
                $display("FAIL wrap_addr byte=%0d got=%h exp=%h", i, bus.mem_address, 16'hFFFE + 16'(i));
            end
            tick();
        end
        n_cmp++;
        if (bus.instr_valid !== 1'b1 || observed() !== model_instr(16'hFFFE)) begin
            n_err++;
            $display("FAIL wrap_instr valid=%b got=%h exp=1/%h", bus.instr_valid, observed(), model_instr(16'hFFFE));
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'h0001) begin
            n_err++;
            $display("FAIL wrap_next got=%h exp=0001", bus.mem_address);
        end
    endtask

    task automatic test_async_reset();
        int c;
        bit ok;
        pulse_reset();
        ram[0] = 8'hA5; ram[1] = 8'h5A; ram[2] = 8'hC3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        n_cmp++;
        if (bus.instr_opcode !== 8'hA5 || bus.mem_address !== 16'h0001) begin
            n_err++;
            $display("FAIL ar_pre opcode=%h addr=%h exp=A5/0001", bus.instr_opcode, bus.mem_address);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.instr_valid, bus.busy, bus.halted, bus.mem_clear} !== 4'b0000 ||
            bus.mem_address !== 16'h0000 || observed() !== 40'h0) begin
            n_err++;
            $display("FAIL ar_async flags=%b addr=%h payload=%h exp=0000/0000/0",
                     {bus.instr_valid, bus.busy, bus.halted, bus.mem_clear}, bus.mem_address, observed());
        end
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.mem_address !== 16'h0000 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL ar_restart addr=%h busy=%b exp=0000/1", bus.mem_address, bus.busy);
        end
        wait_valid(10, c, ok);
        n_cmp++;
        if (!ok || c != 3 || observed() !== model_instr(16'h0000)) begin
            n_err++;
            $display("FAIL ar_instr got=%h cyc=%0d exp=%h/3", observed(), c, model_instr(16'h0000));
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        localparam int N = 12;
        logic [15:0] base;
        logic [15:0] exp_pc;
        logic [15:0] a;
        int got;
        pulse_reset();
        base = 16'($urandom);
        for (int i = 0; i < 3 * N; i++) begin
            a = base + 16'(i);
            ram[a] = 8'($urandom);
            if ((i % 3) == 0 && ram[a] == 8'hFF) ram[a] = 8'h00;
        end
        a = base + 16'(3 * N);
        ram[a] = 8'hFF;
        exp_pc = base;
        got = 0;
        bus.start = 1'b1;
        bus.jump_valid = 1'b1;
        bus.jump_addr = base;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.mem_address !== base || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rnd_start addr=%h busy=%b exp=%h/1", bus.mem_address, bus.busy, base);
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (bus.halted === 1'b1) break;
            if (bus.instr_valid === 1'b1) begin
                n_cmp++;
                if (observed() !== model_instr(exp_pc)) begin
                    n_err++;
                    $display("FAIL rnd_payload idx=%0d got=%h exp=%h", got, observed(), model_instr(exp_pc));
                end
            end
            bus.instr_ready = 1'($urandom_range(0, 1));
            if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                exp_pc = exp_pc + 16'd3;
                got++;
            end
        end
        bus.instr_ready = 1'b0;
        n_cmp++;
        if (got != N || bus.halted !== 1'b1 || bus.mem_address !== exp_pc) begin
            n_err++;
            $display("FAIL rnd_end accepted=%0d halted=%b addr=%h exp=%0d/1/%h",
                     got, bus.halted, bus.mem_address, N, exp_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_program();
        test_clear();
        test_clear_ignored();
        test_jump();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
